// File: rtl/mcu_pkg.sv
// Shared encodings for the multi-cycle control unit: FSM states, RV32I opcodes,
// writeback / PC source select codes and i_format bit positions.
package mcu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6,
    ST_ERROR  = 3'd7
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_TARGET = 2'd1;
  localparam logic [1:0] PC_JALR   = 2'd2;

  localparam logic [2:0] RWM_ALU  = 3'b000;
  localparam logic [2:0] RWM_DMEM = 3'b001;
  localparam logic [2:0] RWM_PC4  = 3'b010;
  localparam logic [2:0] RWM_IMM  = 3'b100;

  localparam int IF_R = 0;
  localparam int IF_I = 1;
  localparam int IF_S = 2;
  localparam int IF_B = 3;
  localparam int IF_U = 4;
  localparam int IF_J = 5;

endpackage

// File: rtl/mcu_decoder.sv
// Combinational decode of the latched opcode/funct7 into instruction class,
// format one-hot and the static datapath selects used by the sequencer.
module mcu_decoder
  import mcu_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [6:0] funct7,
  output logic [5:0] i_format,
  output logic       alu_mux,
  output logic [2:0] reg_write_mux,
  output logic       is_load,
  output logic       is_store,
  output logic       is_branch,
  output logic       is_jal,
  output logic       is_jalr,
  output logic       is_nop,
  output logic       illegal
);

  always_comb begin
    i_format      = '0;
    alu_mux       = 1'b0;
    reg_write_mux = RWM_ALU;
    is_load       = 1'b0;
    is_store      = 1'b0;
    is_branch     = 1'b0;
    is_jal        = 1'b0;
    is_jalr       = 1'b0;
    is_nop        = 1'b0;
    illegal       = 1'b0;
    case (opcode)
      OP_R: begin
        i_format[IF_R] = 1'b1;
        illegal        = (funct7 != 7'h00) && (funct7 != 7'h20);
      end
      OP_I: begin
        i_format[IF_I] = 1'b1;
        alu_mux        = 1'b1;
      end
      OP_LOAD: begin
        i_format[IF_I] = 1'b1;
        alu_mux        = 1'b1;
        is_load        = 1'b1;
        reg_write_mux  = RWM_DMEM;
      end
      OP_STORE: begin
        i_format[IF_S] = 1'b1;
        alu_mux        = 1'b1;
        is_store       = 1'b1;
      end
      OP_BRANCH: begin
        i_format[IF_B] = 1'b1;
        is_branch      = 1'b1;
      end
      OP_JAL: begin
        i_format[IF_J] = 1'b1;
        is_jal         = 1'b1;
        reg_write_mux  = RWM_PC4;
      end
      OP_JALR: begin
        i_format[IF_I] = 1'b1;
        alu_mux        = 1'b1;
        is_jalr        = 1'b1;
        reg_write_mux  = RWM_PC4;
      end
      OP_LUI: begin
        i_format[IF_U] = 1'b1;
        alu_mux        = 1'b1;
        reg_write_mux  = RWM_IMM;
      end
      OP_AUIPC: begin
        i_format[IF_U] = 1'b1;
        alu_mux        = 1'b1;
      end
      // FENCE and SYSTEM are recognised but have no effect in this core
      OP_FENCE, OP_SYSTEM: begin
        is_nop = 1'b1;
      end
      default: begin
        is_nop  = 1'b1;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with req/ack memories and a wait timeout.
// Define MCU_ILLEGAL_TRAP_EN to route illegal instructions through a TRAP state with illegal_instr.
module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       imem_ack,
  input  logic       dmem_ack,
  input  logic       branch_taken,
  output logic [2:0] state,
  output logic       imem_req,
  output logic       ir_write_enable,
  output logic       pc_write_enable,
  output logic [1:0] pc_src,
  output logic       alu_mux,
  output logic [2:0] reg_write_mux,
  output logic       reg_write_enable,
  output logic       dmem_read_enable,
  output logic       dmem_write_enable,
  output logic [5:0] i_format,
`ifdef MCU_ILLEGAL_TRAP_EN
  output logic       illegal_instr,
`endif
  output logic       mem_error
);

  state_e           state_q, state_d;
  logic [6:0]       opcode_q, opcode_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [6:0]       funct7_q, funct7_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             timeout_hit;

  logic [5:0] dec_i_format;
  logic       dec_alu_mux;
  logic [2:0] dec_reg_write_mux;
  logic       dec_is_load, dec_is_store, dec_is_branch;
  logic       dec_is_jal, dec_is_jalr, dec_is_nop, dec_illegal;
  logic       exec_trap;
  logic       unused_fields;

  mcu_decoder u_decoder (
    .opcode        (opcode_q),
    .funct7        (funct7_q),
    .i_format      (dec_i_format),
    .alu_mux       (dec_alu_mux),
    .reg_write_mux (dec_reg_write_mux),
    .is_load       (dec_is_load),
    .is_store      (dec_is_store),
    .is_branch     (dec_is_branch),
    .is_jal        (dec_is_jal),
    .is_jalr       (dec_is_jalr),
    .is_nop        (dec_is_nop),
    .illegal       (dec_illegal)
  );

  // funct3 is latched for the datapath's ALU control; sequencing never depends on it
`ifdef MCU_ILLEGAL_TRAP_EN
  assign exec_trap     = dec_illegal;
  assign unused_fields = ^funct3_q;
`else
  assign exec_trap     = 1'b0;
  assign unused_fields = ^{funct3_q, dec_illegal};
`endif

  assign cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt_q == CNT_W'(MEM_TIMEOUT));

  assign state    = state_q;
  assign i_format = dec_i_format;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      opcode_q <= '0;
      funct3_q <= '0;
      funct7_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      funct3_q <= funct3_d;
      funct7_q <= funct7_d;
      cnt_q    <= cnt_d;
    end
  end

  // The counter is zero in every state except while a request is outstanding, so
  // each entry into FETCH or MEM starts counting from zero.
  always_comb begin
    state_d           = state_q;
    opcode_d          = opcode_q;
    funct3_d          = funct3_q;
    funct7_d          = funct7_q;
    cnt_d             = '0;
    imem_req          = 1'b0;
    ir_write_enable   = 1'b0;
    pc_write_enable   = 1'b0;
    pc_src            = PC_PLUS4;
    alu_mux           = 1'b0;
    reg_write_mux     = RWM_ALU;
    reg_write_enable  = 1'b0;
    dmem_read_enable  = 1'b0;
    dmem_write_enable = 1'b0;
    mem_error         = 1'b0;
`ifdef MCU_ILLEGAL_TRAP_EN
    illegal_instr     = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_write_enable = 1'b1;
          state_d         = ST_DECODE;
        end else if (timeout_hit) begin
          state_d = ST_ERROR;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_DECODE: begin
        opcode_d = opcode;
        funct3_d = funct3;
        funct7_d = funct7;
        state_d  = ST_EXEC;
      end
      ST_EXEC: begin
        alu_mux       = dec_alu_mux;
        reg_write_mux = dec_reg_write_mux;
        if (exec_trap) begin
          state_d = ST_TRAP;
        end else if (dec_is_load || dec_is_store) begin
          state_d = ST_MEM;
        end else if (dec_is_branch) begin
          pc_write_enable = 1'b1;
          pc_src          = branch_taken ? PC_TARGET : PC_PLUS4;
          state_d         = ST_FETCH;
        end else if (dec_is_nop) begin
          pc_write_enable = 1'b1;
          state_d         = ST_FETCH;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        alu_mux           = dec_alu_mux;
        reg_write_mux     = dec_reg_write_mux;
        dmem_read_enable  = dec_is_load;
        dmem_write_enable = dec_is_store;
        if (dmem_ack) begin
          if (dec_is_load) begin
            state_d = ST_WB;
          end else begin
            pc_write_enable = 1'b1;
            state_d         = ST_FETCH;
          end
        end else if (timeout_hit) begin
          state_d = ST_ERROR;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_WB: begin
        alu_mux          = dec_alu_mux;
        reg_write_mux    = dec_reg_write_mux;
        reg_write_enable = 1'b1;
        pc_write_enable  = 1'b1;
        if (dec_is_jal) begin
          pc_src = PC_TARGET;
        end else if (dec_is_jalr) begin
          pc_src = PC_JALR;
        end
        state_d = ST_FETCH;
      end
      // The PC write here is the step over the trapped instruction as TRAP hands back to FETCH
      ST_TRAP: begin
`ifdef MCU_ILLEGAL_TRAP_EN
        illegal_instr   = 1'b1;
`endif
        pc_write_enable = 1'b1;
        state_d         = ST_FETCH;
      end
      ST_ERROR: begin
        mem_error = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-cycle stimulus and expected outputs are queued
// per instruction, then popped and compared as the DUT steps through each cycle.
module tb_multicycle_control_unit;
  import mcu_pkg::*;

  localparam int TO = 4;
  localparam logic [21:0] M_AM  = 22'h002000;
  localparam logic [21:0] M_RWM = 22'h001C00;
  localparam logic [21:0] M_IF  = 22'h00007E;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       imem_ack, dmem_ack, branch_taken;
  logic [2:0] state;
  logic       imem_req, ir_write_enable, pc_write_enable;
  logic [1:0] pc_src;
  logic       alu_mux;
  logic [2:0] reg_write_mux;
  logic       reg_write_enable, dmem_read_enable, dmem_write_enable;
  logic [5:0] i_format;
  logic       mem_error;
`ifdef MCU_ILLEGAL_TRAP_EN
  logic       illegal_instr;
`endif

  multicycle_control_unit #(.MEM_TIMEOUT(TO), .CNT_W(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .opcode            (opcode),
    .funct3            (funct3),
    .funct7            (funct7),
    .imem_ack          (imem_ack),
    .dmem_ack          (dmem_ack),
    .branch_taken      (branch_taken),
    .state             (state),
    .imem_req          (imem_req),
    .ir_write_enable   (ir_write_enable),
    .pc_write_enable   (pc_write_enable),
    .pc_src            (pc_src),
    .alu_mux           (alu_mux),
    .reg_write_mux     (reg_write_mux),
    .reg_write_enable  (reg_write_enable),
    .dmem_read_enable  (dmem_read_enable),
    .dmem_write_enable (dmem_write_enable),
    .i_format          (i_format),
`ifdef MCU_ILLEGAL_TRAP_EN
    .illegal_instr     (illegal_instr),
`endif
    .mem_error         (mem_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ia;
    logic       da;
    logic       bt;
    logic [6:0] op;
    logic [6:0] f7;
  } stim_t;

  typedef struct {
    logic [21:0] val;
    logic [21:0] mask;
    string       tag;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  int    total = 0;
  int    bad   = 0;

  function automatic logic [21:0] pk(logic [2:0] st, logic ireq, logic irw, logic pcw,
                                     logic [1:0] pcs, logic am, logic [2:0] rwm, logic rwe,
                                     logic dre, logic dwe, logic [5:0] ifm, logic me);
    return {st, ireq, irw, pcw, pcs, am, rwm, rwe, dre, dwe, ifm, me};
  endfunction

  function automatic logic [21:0] obs();
    return pk(state, imem_req, ir_write_enable, pc_write_enable, pc_src, alu_mux,
              reg_write_mux, reg_write_enable, dmem_read_enable, dmem_write_enable,
              i_format, mem_error);
  endfunction

  function automatic stim_t mk(logic ia, logic da, logic bt, logic [6:0] op, logic [6:0] f7);
    return {ia, da, bt, op, f7};
  endfunction

  task automatic push(input stim_t s, input logic [21:0] v, input logic [21:0] m, input string tag);
    exp_t e;
    e.val  = v;
    e.mask = m;
    e.tag  = tag;
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  // di/dd: cycles of ack delay for instruction/data memory; negative means the ack never comes
  task automatic add_instr(input string nm, input logic [6:0] op, input logic [6:0] f7,
                           input int di, input int dd, input logic taken, input logic noise);
    logic r, i, ld, st, br, jal, jalr, lui, aui, nop;
    logic [5:0] ifm;
    logic am;
    logic [2:0] rwm;
    logic [1:0] wpcs;
    logic [21:0] mf, me, mm, mw;
    int nf, nmem;
    r    = (op == 7'b0110011);
    i    = (op == 7'b0010011);
    ld   = (op == 7'b0000011);
    st   = (op == 7'b0100011);
    br   = (op == 7'b1100011);
    jal  = (op == 7'b1101111);
    jalr = (op == 7'b1100111);
    lui  = (op == 7'b0110111);
    aui  = (op == 7'b0010111);
    nop  = !(r | i | ld | st | br | jal | jalr | lui | aui);
    ifm  = r ? 6'b000001 : (i | ld | jalr) ? 6'b000010 : st ? 6'b000100 :
           br ? 6'b001000 : (lui | aui) ? 6'b010000 : jal ? 6'b100000 : 6'b000000;
    am   = i | ld | st | jalr | lui | aui;
    rwm  = lui ? 3'b100 : (jal | jalr) ? 3'b010 : ld ? 3'b001 : 3'b000;
    wpcs = jal ? 2'd1 : jalr ? 2'd2 : 2'd0;
    mf   = ~(M_AM | M_RWM | M_IF);
    me   = (jal | nop) ? ~(M_AM | M_RWM) : ~M_RWM;
    mm   = ~(M_AM | M_RWM);
    mw   = ~M_AM;
    nf   = (di < 0) ? TO : di;
    for (int k = 0; k <= nf; k++)
      push(mk(k == di, noise, 1'b0, op, f7),
           pk(3'd1, 1'b1, k == di, 1'b0, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0),
           mf, {nm, "/fetch"});
    if (di < 0) return;
    push(mk(noise, noise, 1'b0, op, f7),
         pk(3'd2, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0),
         mf, {nm, "/decode"});
`ifdef MCU_ILLEGAL_TRAP_EN
    if (nop || (r && f7 != 7'h00 && f7 != 7'h20)) begin
      push(mk(noise, noise, taken, op, f7),
           pk(3'd3, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, ifm, 1'b0),
           me, {nm, "/exec"});
      push(mk(noise, noise, 1'b0, op, f7),
           pk(3'd6, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0),
           mf, {nm, "/trap"});
      return;
    end
`endif
    push(mk(noise, noise, taken, op, f7),
         pk(3'd3, 1'b0, 1'b0, br | nop, (br & taken) ? 2'd1 : 2'd0, am, 3'd0,
            1'b0, 1'b0, 1'b0, ifm, 1'b0),
         me, {nm, "/exec"});
    if (br | nop) return;
    if (ld | st) begin
      nmem = (dd < 0) ? TO : dd;
      for (int k = 0; k <= nmem; k++)
        push(mk(noise, k == dd, 1'b0, op, f7),
             pk(3'd4, 1'b0, 1'b0, st && (k == dd), 2'd0, 1'b0, 3'd0, 1'b0, ld, st, ifm, 1'b0),
             mm, {nm, "/mem"});
      if (dd < 0 || st) return;
    end
    push(mk(noise, noise, 1'b0, op, f7),
         pk(3'd5, 1'b0, 1'b0, 1'b1, wpcs, 1'b0, rwm, 1'b1, 1'b0, 1'b0, ifm, 1'b0),
         mw, {nm, "/wb"});
  endtask

  task automatic add_error(input int n);
    for (int k = 0; k < n; k++)
      push(mk(1'b1, 1'b1, 1'b0, 7'h7F, 7'h00),
           pk(3'd7, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1),
           ~(M_AM | M_RWM | M_IF), "error");
  endtask

  task automatic run_n(input int n);
    for (int k = 0; k < n; k++) begin
      stim_t s;
      exp_t e;
      logic [21:0] o;
      s = stim_q.pop_front();
      @(posedge clk);
      #1;
      imem_ack     = s.ia;
      dmem_ack     = s.da;
      branch_taken = s.bt;
      opcode       = s.op;
      funct7       = s.f7;
      funct3       = 3'b000;
      @(negedge clk);
      e = exp_q.pop_front();
      o = obs();
      total++;
      assert ((o & e.mask) === (e.val & e.mask))
      else begin
        bad++;
        $error("FAIL %s: observed=%h expected=%h", e.tag, o & e.mask, e.val & e.mask);
      end
    end
  endtask

  task automatic run_all();
    run_n(stim_q.size());
  endtask

  task automatic check_zero(input string tag);
    logic [21:0] o;
    o = obs();
    total++;
    assert (o === 22'h0)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, o, 22'h0);
    end
  endtask

  task automatic idle_inputs();
    imem_ack     = 1'b0;
    dmem_ack     = 1'b0;
    branch_taken = 1'b0;
    opcode       = 7'h00;
    funct3       = 3'b000;
    funct7       = 7'h00;
  endtask

  task automatic pulse_reset(input string tag);
    #2;
    rst = 1'b1;
    idle_inputs();
    #1;
    check_zero({tag, "/in_reset"});
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_zero({tag, "/idle"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    #3;
    check_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_zero("idle");

    add_instr("add",      7'b0110011, 7'h00, 1, 0, 1'b0, 1'b0);
    add_instr("lw",       7'b0000011, 7'h00, 1, 3, 1'b0, 1'b0);
    add_instr("beq_t",    7'b1100011, 7'h00, 0, 0, 1'b1, 1'b0);
    add_instr("beq_nt",   7'b1100011, 7'h00, 0, 0, 1'b0, 1'b0);
    add_instr("jalr",     7'b1100111, 7'h00, 0, 0, 1'b0, 1'b0);
    add_instr("nop_7f",   7'b1111111, 7'h00, 0, 0, 1'b0, 1'b0);
    add_instr("sw",       7'b0100011, 7'h00, 0, 0, 1'b0, 1'b0);
    add_instr("lui",      7'b0110111, 7'h00, 2, 0, 1'b0, 1'b1);
    add_instr("jal",      7'b1101111, 7'h00, 0, 0, 1'b0, 1'b1);
    add_instr("auipc",    7'b0010111, 7'h00, 0, 0, 1'b0, 1'b0);
    add_instr("addi",     7'b0010011, 7'h00, 0, 0, 1'b0, 1'b1);
    add_instr("sub_edge", 7'b0110011, 7'h20, TO, 0, 1'b0, 1'b0);
    add_instr("sw_edge",  7'b0100011, 7'h00, 0, TO, 1'b0, 1'b0);
    add_instr("lw_fast",  7'b0000011, 7'h00, 0, 0, 1'b0, 1'b1);
    run_all();

    add_instr("fetch_to", 7'b0110011, 7'h00, -1, 0, 1'b0, 1'b0);
    add_error(3);
    run_all();
    pulse_reset("fetch_to");

    add_instr("mem_to", 7'b0100011, 7'h00, 0, -1, 1'b0, 1'b0);
    add_error(2);
    run_all();
    pulse_reset("mem_to");

    add_instr("lw_cut", 7'b0000011, 7'h00, 0, 3, 1'b0, 1'b0);
    run_n(5);
    stim_q.delete();
    exp_q.delete();
    pulse_reset("lw_cut");

    add_instr("add_after", 7'b0110011, 7'h00, 0, 0, 1'b0, 1'b0);
    run_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
